// File: rtl/shift_issue_stage_if.sv
// Shift issue stage bus interface.
// Groups the upstream (ID -> stage) and downstream (stage -> EX shifter)
// handshake and payload signals.
//   master : the environment side (drives in_*, operands and out_ready)
//   slave  : the stage itself (drives in_ready and all registered outputs)
interface shift_issue_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_in;
    logic [4:0]  shift_amount;
    logic        shift_mode;
    logic        arithmetic_en;
    logic        illegal;

    modport master (
        output in_valid, instr, rs1_data, rs2_data, out_ready,
        input  in_ready, out_valid, data_in, shift_amount, shift_mode,
               arithmetic_en, illegal
    );

    modport slave (
        input  in_valid, instr, rs1_data, rs2_data, out_ready,
        output in_ready, out_valid, data_in, shift_amount, shift_mode,
               arithmetic_en, illegal
    );
endinterface

// File: rtl/shift_issue_stage.sv
// Shift issue stage: decodes RV32I shift instructions (SLL/SRL/SRA and
// SLLI/SRLI/SRAI) and presents the shifter operands through a two-entry
// skid buffer with 1-cycle latency and fully registered outputs.
// Ports:
//   clk   : clock, all state on rising edge
//   rst   : synchronous active-high reset (highest priority)
//   flush : pipeline kill, drops held and same-cycle incoming entries
//   bus   : shift_issue_stage_if.slave
//           in_valid/in_ready        upstream handshake
//           instr/rs1_data/rs2_data  instruction word and register operands
//           out_valid/out_ready      downstream handshake
//           data_in, shift_amount, shift_mode, arithmetic_en, illegal
module shift_issue_stage (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    shift_issue_stage_if.slave   bus
);

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  amount;
        logic        mode;
        logic        arith;
        logic        illegal;
    } entry_t;

    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_STD = 7'b0000000;
    localparam logic [6:0] F7_ALT = 7'b0100000;

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   in_ready_q, in_ready_d;

    entry_t dec;
    logic   accept;
    logic   drain;

    // Register/immediate-field bits the shift decode never looks at.
    logic   unused_bits;
    assign unused_bits = ^{bus.instr[19:15], bus.instr[11:7], bus.rs2_data[31:5]};

    // Decode of the incoming instruction
    always_comb begin
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic       legal;
        logic       mode;
        logic       arith;
        logic [4:0] amount;

        opcode = bus.instr[6:0];
        funct3 = bus.instr[14:12];
        funct7 = bus.instr[31:25];
        legal  = 1'b0;
        mode   = 1'b0;
        arith  = 1'b0;
        amount = (opcode == OP_IMM) ? bus.instr[24:20] : bus.rs2_data[4:0];

        // funct7 check also covers instr[25] on immediate shifts (RV32 shamt is 5 bits)
        if (opcode == OP_REG || opcode == OP_IMM) begin
            if (funct3 == 3'b001 && funct7 == F7_STD) begin
                legal = 1'b1;
            end else if (funct3 == 3'b101 && funct7 == F7_STD) begin
                legal = 1'b1;
                mode  = 1'b1;
            end else if (funct3 == 3'b101 && funct7 == F7_ALT) begin
                legal = 1'b1;
                mode  = 1'b1;
                arith = 1'b1;
            end
        end

        dec = '0;
        if (legal) begin
            dec.data   = bus.rs1_data;
            dec.amount = amount;
            dec.mode   = mode;
            dec.arith  = arith;
        end else begin
            dec.illegal = 1'b1;
        end
    end

    assign accept = bus.in_valid & in_ready_q;
    assign drain  = main_valid_q & bus.out_ready;

    // Skid buffer next state. accept implies skid empty because in_ready
    // is the registered inverse of skid valid.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || drain) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = dec;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end

        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = main_valid_q;
    assign bus.data_in       = main_q.data;
    assign bus.shift_amount  = main_q.amount;
    assign bus.shift_mode    = main_q.mode;
    assign bus.arithmetic_en = main_q.arith;
    assign bus.illegal       = main_q.illegal;

endmodule

// File: tb/tb_shift_issue_stage.sv
module tb_shift_issue_stage;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] e_data;
        logic [4:0]  e_amt;
        logic        e_mode;
        logic        e_arith;
        logic        e_ill;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    shift_issue_stage_if bus ();

    shift_issue_stage dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, required finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic check_out(input string tag, input logic v, input logic rdy,
                             input logic [31:0] d, input logic [4:0] a,
                             input logic m, input logic ar, input logic il);
        chk({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, v});
        chk({tag, ".in_ready"},  {31'd0, bus.in_ready},  {31'd0, rdy});
        chk({tag, ".data_in"},   bus.data_in, d);
        chk({tag, ".amount"},    {27'd0, bus.shift_amount}, {27'd0, a});
        chk({tag, ".mode"},      {31'd0, bus.shift_mode},   {31'd0, m});
        chk({tag, ".arith"},     {31'd0, bus.arithmetic_en}, {31'd0, ar});
        chk({tag, ".illegal"},   {31'd0, bus.illegal},      {31'd0, il});
    endtask

    task automatic drive(input logic v, input logic [31:0] ins,
                         input logic [31:0] r1, input logic [31:0] r2);
        bus.in_valid = v;
        bus.instr    = ins;
        bus.rs1_data = r1;
        bus.rs2_data = r2;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{"srai",      32'h4041D093, 32'h80000000, 32'h00000000, 32'h80000000, 5'd4,  1'b1, 1'b1, 1'b0};
        vecs[1]  = '{"sll",       32'h003110B3, 32'h12345678, 32'h00000025, 32'h12345678, 5'd5,  1'b0, 1'b0, 1'b0};
        vecs[2]  = '{"srl",       32'h003150B3, 32'hF0F0F0F0, 32'hFFFFFFFF, 32'hF0F0F0F0, 5'd31, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{"sra",       32'h403150B3, 32'h80000001, 32'h00000020, 32'h80000001, 5'd0,  1'b1, 1'b1, 1'b0};
        vecs[4]  = '{"slli31",    32'h01F11093, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 5'd31, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{"srli0",     32'h0000D093, 32'hCAFEBABE, 32'h00000007, 32'hCAFEBABE, 5'd0,  1'b1, 1'b0, 1'b0};
        vecs[6]  = '{"srli_b25",  32'h0220D093, 32'hDEADBEEF, 32'h00000003, 32'h00000000, 5'd0,  1'b0, 1'b0, 1'b1};
        vecs[7]  = '{"add",       32'h003100B3, 32'h11111111, 32'h00000004, 32'h00000000, 5'd0,  1'b0, 1'b0, 1'b1};
        vecs[8]  = '{"sll_f7alt", 32'h403110B3, 32'h22222222, 32'h00000004, 32'h00000000, 5'd0,  1'b0, 1'b0, 1'b1};
        vecs[9]  = '{"load",      32'h0041D083, 32'h33333333, 32'h00000004, 32'h00000000, 5'd0,  1'b0, 1'b0, 1'b1};
        vecs[10] = '{"slli_f7alt",32'h40011093, 32'h44444444, 32'h00000004, 32'h00000000, 5'd0,  1'b0, 1'b0, 1'b1};
        vecs[11] = '{"divu",      32'h023150B3, 32'h55555555, 32'h00000004, 32'h00000000, 5'd0,  1'b0, 1'b0, 1'b1};

        rst = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h4041D093, 32'hFFFFFFFF, 32'hFFFFFFFF);
        tick();
        tick();
        check_out("reset", 1'b0, 1'b1, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        tick();

        // Back-to-back stream of decode vectors, one per cycle
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, vecs[i].instr, vecs[i].rs1, vecs[i].rs2);
            tick();
            check_out(vecs[i].name, 1'b1, 1'b1, vecs[i].e_data, vecs[i].e_amt,
                      vecs[i].e_mode, vecs[i].e_arith, vecs[i].e_ill);
        end
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        tick();
        chk("idle.out_valid", {31'd0, bus.out_valid}, 32'd0);

        // Backpressure: SLLI held, SRLI skidded, then drained in order
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h00311093, 32'h0000000A, 32'h0);
        tick();
        check_out("bp.first", 1'b1, 1'b1, 32'h0000000A, 5'd3, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h00715093, 32'h0000000B, 32'h0);
        tick();
        check_out("bp.skid", 1'b1, 1'b0, 32'h0000000A, 5'd3, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h4041D093, 32'h0000000C, 32'h0);
        tick();
        check_out("bp.hold", 1'b1, 1'b0, 32'h0000000A, 5'd3, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        bus.out_ready = 1'b1;
        tick();
        check_out("bp.second", 1'b1, 1'b1, 32'h0000000B, 5'd7, 1'b1, 1'b0, 1'b0);
        tick();
        chk("bp.empty.out_valid", {31'd0, bus.out_valid}, 32'd0);

        // Flush with both entries full and a same-cycle input
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h00311093, 32'h00000001, 32'h0);
        tick();
        drive(1'b1, 32'h00715093, 32'h00000002, 32'h0);
        tick();
        chk("fl.pre.in_ready", {31'd0, bus.in_ready}, 32'd0);
        flush = 1'b1;
        drive(1'b1, 32'h4041D093, 32'h00000003, 32'h0);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        chk("fl.out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("fl.in_ready",  {31'd0, bus.in_ready},  32'd1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fl.stale.out_valid", {31'd0, bus.out_valid}, 32'd0);
        end

        // Reset in the middle of streaming with both entries full
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h003110B3, 32'h00000077, 32'h00000009);
        tick();
        drive(1'b1, 32'h403150B3, 32'h00000088, 32'h00000001);
        tick();
        rst = 1'b1;
        flush = 1'b1;
        tick();
        rst = 1'b0;
        flush = 1'b0;
        check_out("rst.mid", 1'b0, 1'b1, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h4041D093, 32'h80000000, 32'h0);
        tick();
        check_out("rst.first", 1'b1, 1'b1, 32'h80000000, 5'd4, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        tick();
        chk("rst.after.out_valid", {31'd0, bus.out_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
